dmac_multi_ctrl: RTL and testbench
==================================

Name: dmac_multi_ctrl

Overview:
- Parametrised main controller for the DMAC. Generalises the two-channel controller to NUM_CH peripheral request lines.
- Selectable fixed-priority or round-robin arbitration, a registered channel selection, and a Moore state machine.
- Grant-loss recovery: re-requests the bus mid-transfer without re-acknowledging the peripheral.
- Sits between peripheral DmacReq lines, the AHB bus arbiter (Bus_Req/Bus_Grant), the slave config block (C_config, con_en/con_sel) and the channel datapaths (ch_en, irq).

Parameters:
- NUM_CH, 4, number of peripheral request lines / channels (2..16).
- RR_MODE, 0, arbitration mode: 0 = fixed priority (highest index wins), 1 = round-robin.
- CH_W, $clog2(NUM_CH), width of the channel index (derived; do not override).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- dmac_req  in  NUM_CH  peripheral DMA requests, level.
- bus_grant  in  1  bus ownership granted by the AHB arbiter.
- c_config  in  1  slave configuration complete.
- irq  in  1  active channel reports transfer complete.
- con_new_sel  in  1  datapath request to switch config select during transfer.
- bus_req  out  1  bus request to the arbiter.
- hold  out  1  bus lock while the DMAC owns or is acquiring the bus.
- con_en  out  1  config interface enable.
- con_sel  out  1  config select.
- ch_en  out  NUM_CH  one-hot enable of the active channel.
- req_ack  out  NUM_CH  one-hot, one-cycle acknowledge to the served peripheral.
- interrupt  out  1  one-cycle completion interrupt.
- active_ch  out  CH_W  index of the latched channel; valid while busy=1.
- busy  out  1  controller not IDLE.

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, ch_q=0, rr_ptr=0, resume=0. All outputs 0. A reset asserted mid-operation aborts immediately, with no interrupt and no ack.
- States: IDLE, REQ, ACK, XFER, DONE. All outputs decode from state and registered ch_q only; no input-to-output combinational path.
- IDLE:
  - Outputs all 0.
  - If any dmac_req is set: ch_q <= arbitration winner; next state REQ.
- Fixed arbitration: highest set index wins.
- Round-robin arbitration: search from rr_ptr upward with wrap; first set bit wins.
- REQ:
  - Outputs: bus_req=1, hold=1.
  - Requests are latched; deassertion of dmac_req here does not cancel.
  - On c_config=1 and bus_grant=1 in the same cycle:
    - resume=0 -> ACK.
    - resume=1 -> XFER, with no ACK and no req_ack.
  - Otherwise stay in REQ.
- ACK (exactly one cycle):
  - Outputs: hold=1, con_en=1, con_sel=1, ch_en[ch_q]=1, req_ack[ch_q]=1.
  - Next state XFER.
- XFER:
  - Outputs: hold=1, con_en=1, ch_en[ch_q]=1, con_sel = registered con_new_sel (1-cycle latency).
  - irq=1 -> DONE. irq has priority over grant loss in the same cycle.
  - else bus_grant=0 -> REQ, resume<=1.
  - else stay in XFER.
- DONE (exactly one cycle):
  - Outputs: interrupt=1, all others 0.
  - resume <= 0.
  - RR_MODE=1: rr_ptr <= (ch_q+1) mod NUM_CH, wrapping from NUM_CH-1 to 0.
  - Next state IDLE. New requests are sampled only from IDLE, so there is a minimum of one idle cycle between transfers.
- busy=1 in every state except IDLE. active_ch=ch_q.
- ch_en and req_ack are always one-hot or zero. Never more than one bit set.
- Latency from request to bus_req: dmac_req sampled high in IDLE -> bus_req high on the next cycle.
- RR_MODE=0: rr_ptr stays 0 and is unused.

Test Plan:
- NUM_CH=4, RR_MODE=0. Reset, then dmac_req=4'b0101. Response: bus_req=1 next cycle, active_ch=2. Drive c_config=bus_grant=1 -> req_ack=4'b0100 for exactly one cycle, then ch_en=4'b0100 held through XFER. Pulse irq -> interrupt for one cycle, then IDLE.
- RR_MODE=1, dmac_req=4'b1111 held for four transfers. Served order: 0,1,2,3. The fifth transfer serves 0 again (wrap).
- In XFER, drop bus_grant for 3 cycles. Response: bus_req=1 and hold=1 during the drop, req_ack stays 0. On regrant with c_config=1, return to XFER with ch_en unchanged.
- In XFER, irq=1 and bus_grant=0 on the same cycle -> DONE. interrupt=1, no re-request.
- In XFER, toggle con_new_sel 0->1 -> con_sel goes 1 exactly one cycle later, con_en stays 1.
- Assert rst=0 for one cycle during ACK and during XFER. On the next cycle every output is 0, state is IDLE, and no interrupt pulse appears.

Source files
------------

// File: rtl/dmac_multi_ctrl.sv
// DMAC main controller for NUM_CH peripheral request lines: arbitrates requests,
// acquires the AHB bus, sequences config/channel enables and recovers from grant loss.
module dmac_multi_ctrl #(
    parameter int NUM_CH  = 4,
    parameter int RR_MODE = 0,
    parameter int CH_W    = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] dmac_req,
    input  logic              bus_grant,
    input  logic              c_config,
    input  logic              irq,
    input  logic              con_new_sel,
    output logic              bus_req,
    output logic              hold,
    output logic              con_en,
    output logic              con_sel,
    output logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] req_ack,
    output logic              interrupt,
    output logic [CH_W-1:0]   active_ch,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ACK,
        XFER,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                resume_q, resume_d;
    logic                sel_q;

    logic [CH_W-1:0]     win;
    logic [NUM_CH-1:0]   ch_onehot;
    logic [2*NUM_CH-1:0] req_dbl;
    logic [NUM_CH-1:0]   req_rot;
    logic [CH_W-1:0]     rr_off;
    logic [CH_W:0]       rr_sum;

    // Arbitration: fixed picks the highest set index; round-robin rotates the
    // request vector so rr_ptr sits at bit 0 and picks the lowest set bit.
    always_comb begin
        win     = '0;
        rr_off  = '0;
        req_dbl = {dmac_req, dmac_req} >> rr_ptr_q;
        req_rot = req_dbl[NUM_CH-1:0];
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_rot[i]) rr_off = CH_W'(i);
        end
        rr_sum = {1'b0, rr_ptr_q} + {1'b0, rr_off};
        if (rr_sum >= (CH_W+1)'(NUM_CH)) rr_sum = rr_sum - (CH_W+1)'(NUM_CH);
        if (RR_MODE != 0) begin
            win = rr_sum[CH_W-1:0];
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (dmac_req[i]) win = CH_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_onehot[i] = (ch_q == CH_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            rr_ptr_q <= '0;
            resume_q <= 1'b0;
            sel_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            rr_ptr_q <= rr_ptr_d;
            resume_q <= resume_d;
            sel_q    <= con_new_sel;
        end
    end

    // Outputs depend only on registered state, so nothing combinational reaches them from inputs.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        rr_ptr_d  = rr_ptr_q;
        resume_d  = resume_q;
        bus_req   = 1'b0;
        hold      = 1'b0;
        con_en    = 1'b0;
        con_sel   = 1'b0;
        ch_en     = '0;
        req_ack   = '0;
        interrupt = 1'b0;
        case (state_q)
            IDLE: begin
                if (|dmac_req) begin
                    ch_d    = win;
                    state_d = REQ;
                end
            end
            REQ: begin
                bus_req = 1'b1;
                hold    = 1'b1;
                if (c_config && bus_grant) state_d = resume_q ? XFER : ACK;
            end
            ACK: begin
                hold    = 1'b1;
                con_en  = 1'b1;
                con_sel = 1'b1;
                ch_en   = ch_onehot;
                req_ack = ch_onehot;
                state_d = XFER;
            end
            XFER: begin
                hold    = 1'b1;
                con_en  = 1'b1;
                con_sel = sel_q;
                ch_en   = ch_onehot;
                if (irq) begin
                    state_d = DONE;
                end else if (!bus_grant) begin
                    state_d  = REQ;
                    resume_d = 1'b1;
                end
            end
            DONE: begin
                interrupt = 1'b1;
                resume_d  = 1'b0;
                if (RR_MODE != 0) begin
                    rr_ptr_d = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign active_ch = ch_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dmac_multi_ctrl.sv
// Scoreboard bench: a fixed-priority and a round-robin controller share stimulus;
// a reference model predicts acks/interrupt channels, a negedge monitor checks them.
module tb_dmac_multi_ctrl;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] dmac_req = '0;
    logic         bus_grant = 1'b0, c_config = 1'b0, irq = 1'b0, con_new_sel = 1'b0;

    logic         bus_req_f, hold_f, con_en_f, con_sel_f, interrupt_f, busy_f;
    logic [N-1:0] ch_en_f, req_ack_f;
    logic [1:0]   active_ch_f;
    logic         bus_req_r, hold_r, con_en_r, con_sel_r, interrupt_r, busy_r;
    logic [N-1:0] ch_en_r, req_ack_r;
    logic [1:0]   active_ch_r;

    dmac_multi_ctrl #(.NUM_CH(N), .RR_MODE(0)) u_fix (
        .clk(clk), .rst(rst), .dmac_req(dmac_req), .bus_grant(bus_grant),
        .c_config(c_config), .irq(irq), .con_new_sel(con_new_sel),
        .bus_req(bus_req_f), .hold(hold_f), .con_en(con_en_f), .con_sel(con_sel_f),
        .ch_en(ch_en_f), .req_ack(req_ack_f), .interrupt(interrupt_f),
        .active_ch(active_ch_f), .busy(busy_f)
    );

    dmac_multi_ctrl #(.NUM_CH(N), .RR_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .dmac_req(dmac_req), .bus_grant(bus_grant),
        .c_config(c_config), .irq(irq), .con_new_sel(con_new_sel),
        .bus_req(bus_req_r), .hold(hold_r), .con_en(con_en_r), .con_sel(con_sel_r),
        .ch_en(ch_en_r), .req_ack(req_ack_r), .interrupt(interrupt_r),
        .active_ch(active_ch_r), .busy(busy_r)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int ack_f_q[$], ack_r_q[$], int_f_q[$], int_r_q[$];
    int rr_ptr_m = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int fix_win(input logic [N-1:0] r);
        for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
        return 0;
    endfunction

    function automatic int rr_win(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string name);
        chk({name, "_f"}, {bus_req_f, hold_f, con_en_f, con_sel_f, ch_en_f, req_ack_f,
                           interrupt_f, active_ch_f, busy_f}, 0);
        chk({name, "_r"}, {bus_req_r, hold_r, con_en_r, con_sel_r, ch_en_r, req_ack_r,
                           interrupt_r, active_ch_r, busy_r}, 0);
    endtask

    task automatic do_reset(input string name);
        bus_grant = 1'b0; c_config = 1'b0; irq = 1'b0; dmac_req = '0; con_new_sel = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_zero(name);
        int_f_q.delete();
        int_r_q.delete();
        rr_ptr_m = 0;
        tick();
        chk({name, "_no_irq"}, {interrupt_f, interrupt_r, busy_f, busy_r}, 0);
    endtask

    // abort: 0 none, 1 reset during ACK, 2 reset during XFER
    task automatic xfer(input logic [N-1:0] req, input bit keep, input int req_wait,
                        input int drops, input bit irq_loss, input bit sel_tog, input int abort);
        int ef, er;
        ef = fix_win(req);
        er = rr_win(req, rr_ptr_m);
        dmac_req = req;
        ack_f_q.push_back(1 << ef);
        ack_r_q.push_back(1 << er);
        int_f_q.push_back(ef);
        int_r_q.push_back(er);
        chk("idle_bus_req", {bus_req_f, bus_req_r}, 0);
        tick();
        if (!keep) dmac_req = '0;
        chk("req_bus_req", {bus_req_f, hold_f, busy_f, bus_req_r, hold_r, busy_r}, 6'b111111);
        chk("req_ch_f", active_ch_f, ef);
        chk("req_ch_r", active_ch_r, er);
        for (int w = 0; w < req_wait; w++) begin
            tick();
            chk("req_wait", {bus_req_f, req_ack_f, bus_req_r, req_ack_r}, {1'b1, 4'b0, 1'b1, 4'b0});
        end
        bus_grant = 1'b1; c_config = 1'b1;
        tick();
        c_config = 1'b0;
        chk("ack_ctrl", {bus_req_f, hold_f, con_en_f, con_sel_f}, 4'b0111);
        chk("ack_req_ack_f", req_ack_f, 1 << ef);
        chk("ack_req_ack_r", req_ack_r, 1 << er);
        if (abort == 1) begin
            do_reset("rst_in_ack");
            return;
        end
        tick();
        chk("xfer_ctrl", {bus_req_f, hold_f, con_en_f, con_sel_f, req_ack_f}, {4'b0110, 4'b0});
        chk("xfer_ch_en_f", ch_en_f, 1 << ef);
        chk("xfer_ch_en_r", ch_en_r, 1 << er);
        if (sel_tog) begin
            con_new_sel = 1'b1;
            chk("sel_before", {con_sel_f, con_sel_r}, 0);
            tick();
            chk("sel_after", {con_sel_f, con_en_f, con_sel_r, con_en_r}, 4'b1111);
            con_new_sel = 1'b0;
            tick();
            chk("sel_back", {con_sel_f, con_sel_r}, 0);
        end
        if (drops > 0) begin
            bus_grant = 1'b0;
            for (int d = 0; d < drops; d++) begin
                tick();
                chk("drop_f", {bus_req_f, hold_f, req_ack_f, ch_en_f}, {2'b11, 8'b0});
                chk("drop_r", {bus_req_r, hold_r, req_ack_r, ch_en_r}, {2'b11, 8'b0});
            end
            bus_grant = 1'b1; c_config = 1'b1;
            tick();
            c_config = 1'b0;
            chk("regrant_ch_en_f", {ch_en_f, req_ack_f}, {4'(1 << ef), 4'b0});
            chk("regrant_ch_en_r", {ch_en_r, req_ack_r}, {4'(1 << er), 4'b0});
            chk("regrant_ctrl", {bus_req_f, hold_f, con_en_f}, 3'b011);
        end
        if (abort == 2) begin
            do_reset("rst_in_xfer");
            return;
        end
        irq = 1'b1;
        if (irq_loss) bus_grant = 1'b0;
        tick();
        irq = 1'b0; bus_grant = 1'b0;
        chk("done", {interrupt_f, busy_f, bus_req_f, hold_f, ch_en_f},
                    {2'b11, 2'b00, 4'b0});
        chk("done_r", {interrupt_r, busy_r, bus_req_r, hold_r, ch_en_r},
                      {2'b11, 2'b00, 4'b0});
        rr_ptr_m = (er + 1) % N;
        tick();
        chk("back_idle", {busy_f, interrupt_f, bus_req_f, busy_r, interrupt_r, bus_req_r}, 0);
    endtask

    // Monitor: every ack/interrupt the DUTs present is matched against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (req_ack_f != '0) begin
                if (ack_f_q.size() == 0) chk("unexpected_ack_f", req_ack_f, 0);
                else chk("sb_ack_f", req_ack_f, ack_f_q.pop_front());
            end
            if (req_ack_r != '0) begin
                if (ack_r_q.size() == 0) chk("unexpected_ack_r", req_ack_r, 0);
                else chk("sb_ack_r", req_ack_r, ack_r_q.pop_front());
            end
            if (interrupt_f) begin
                if (int_f_q.size() == 0) chk("unexpected_irq_f", interrupt_f, 0);
                else chk("sb_irq_ch_f", active_ch_f, int_f_q.pop_front());
            end
            if (interrupt_r) begin
                if (int_r_q.size() == 0) chk("unexpected_irq_r", interrupt_r, 0);
                else chk("sb_irq_ch_r", active_ch_r, int_r_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b1;
        mon_en = 1'b1;
        tick();
        chk("idle_stays", {busy_f, busy_r, bus_req_f, bus_req_r}, 0);

        xfer(4'b0101, 1'b0, 1, 0, 1'b0, 1'b0, 0);
        do_reset("reset_between");
        repeat (5) xfer(4'b1111, 1'b1, 0, 0, 1'b0, 1'b0, 0);
        dmac_req = '0;
        xfer(4'b1010, 1'b0, 0, 3, 1'b0, 1'b0, 0);
        xfer(4'b0110, 1'b0, 0, 0, 1'b1, 1'b0, 0);
        xfer(4'b0011, 1'b0, 0, 0, 1'b0, 1'b1, 0);
        xfer(4'b1001, 1'b0, 0, 0, 1'b0, 1'b0, 1);
        xfer(4'b0111, 1'b0, 0, 2, 1'b0, 1'b0, 2);

        for (int t = 0; t < 40; t++) begin
            logic [N-1:0] r;
            int ab;
            r  = N'($urandom_range(1, 15));
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
            xfer(r, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ab);
            dmac_req = '0;
        end
        tick();
        tick();
        chk("sb_empty", ack_f_q.size() + ack_r_q.size() + int_f_q.size() + int_r_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
